// File: rtl/display_scan_scheduler.sv
// Multiplexed 7-segment scan scheduler: one shared decoder, active-low digit enables,
// double-buffered display values applied only at frame boundaries.
module display_scan_scheduler #(
   parameter int N_DIGITS = 4,
   parameter int PRESCALE = 50000,
   parameter int GUARD    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic [4*N_DIGITS-1:0] data_in_i,
   input  logic [N_DIGITS-1:0]   dp_in_i,
   input  logic                  load_i,
   input  logic                  lz_blank_i,
   output logic [3:0]            d7seg_o,
   output logic                  dp_out_o,
   output logic [N_DIGITS-1:0]   dig_sel_n_o,
   output logic                  busy_o,
   output logic                  upd_ack_o,
   output logic                  frame_tick_o
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] act_q, act_d;
   logic [N_DIGITS-1:0]   dpa_q, dpa_d;
   logic [4*N_DIGITS-1:0] sh_q, sh_d;
   logic [N_DIGITS-1:0]   dps_q, dps_d;
   logic                  busy_q, busy_d;
   logic [3:0]            d7seg_q, d7seg_d;
   logic                  dp_out_q, dp_out_d;
   logic [N_DIGITS-1:0]   dig_q, dig_d;
   logic                  ack_q, ack_d;
   logic                  tick_q, tick_d;
   logic                  apply;
   logic [N_DIGITS-1:0]   supp;

   // The registered frame tick marks the boundary cycle, so the swap lands on its closing edge.
   assign apply = tick_q & busy_q;

   always_comb begin : scan_fsm
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!enable_i) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == GUARD_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_BLANK;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_BLANK;
         endcase
      end
   end

   always_comb begin : load_path
      sh_d   = sh_q;
      dps_d  = dps_q;
      act_d  = act_q;
      dpa_d  = dpa_q;
      busy_d = busy_q;
      if (apply) begin
         act_d  = sh_q;
         dpa_d  = dps_q;
         busy_d = 1'b0;
      end
      // A load on the boundary cycle refills the shadow after the swap above.
      if (load_i) begin
         sh_d   = data_in_i;
         dps_d  = dp_in_i;
         busy_d = 1'b1;
      end
   end

   always_comb begin : lz_suppress
      logic zero_run;
      zero_run = 1'b1;
      supp     = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (act_d[4*i +: 4] == 4'h0);
         supp[i]  = lz_blank_i & zero_run;
      end
   end

   // Output registers are fed from next-state so they line up with the state they describe.
   always_comb begin : out_next
      d7seg_d  = act_d[{idx_d, 2'b00} +: 4];
      dp_out_d = dpa_d[idx_d];
      dig_d    = '1;
      if ((state_d == ST_SHOW) && !supp[idx_d]) dig_d[idx_d] = 1'b0;
      tick_d   = (state_d == ST_SHOW) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
      ack_d    = tick_d & busy_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: display and shadow registers are plain flops and are cleared, so reset also drops a pending load.
         state_q  <= ST_BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         act_q    <= '0;
         dpa_q    <= '0;
         sh_q     <= '0;
         dps_q    <= '0;
         busy_q   <= 1'b0;
         d7seg_q  <= 4'h0;
         dp_out_q <= 1'b0;
         dig_q    <= '1;
         ack_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         act_q    <= act_d;
         dpa_q    <= dpa_d;
         sh_q     <= sh_d;
         dps_q    <= dps_d;
         busy_q   <= busy_d;
         d7seg_q  <= d7seg_d;
         dp_out_q <= dp_out_d;
         dig_q    <= dig_d;
         ack_q    <= ack_d;
         tick_q   <= tick_d;
      end
   end

   assign d7seg_o      = d7seg_q;
   assign dp_out_o     = dp_out_q;
   assign dig_sel_n_o  = dig_q;
   assign busy_o       = busy_q;
   assign upd_ack_o    = ack_q;
   assign frame_tick_o = tick_q;

endmodule
